relu_maxpool: RTL and testbench

Downstream post-processing stage for the convolution accelerator. It consumes the row-major stream of convolution results, optionally applies ReLU, and performs 2x2 stride-2 max pooling using a half-row line buffer. It emits one pooled value per 2x2 window on an AXI-Stream-style output, with TLAST on the final value of each frame.

---
 rtl/relu_maxpool_pkg.sv | 32 +++
 rtl/relu_maxpool_if.sv | 31 +++
 rtl/relu_maxpool_linebuf.sv | 36 +++
 rtl/relu_maxpool.sv | 167 ++++++++++++++++
 tb/tb_relu_maxpool.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/relu_maxpool_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : relu_maxpool_pkg
//  Purpose  : Shared types, default sizes and the signed-max helper for the
//             ReLU + 2x2 max-pool post-processing stage.
//  Revision : 1.0  initial release
// ============================================================================
package relu_maxpool_pkg;

  // Default geometry; DW matches the convolution output for INW=18, MAXK=5.
  localparam int DW_DEF    = 40;
  localparam int C_MAX_DEF = 8;
  localparam int R_MAX_DEF = 8;

  // The line buffer holds one horizontal max per column pair of a row.
  localparam int LB_DEPTH  = C_MAX_DEF / 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Signed maximum at full data width, no widening.
  function automatic logic signed [DW_DEF-1:0] smax(
    input logic signed [DW_DEF-1:0] a,
    input logic signed [DW_DEF-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/relu_maxpool_if.sv
`default_nettype none
// ============================================================================
//  Module   : relu_maxpool_if
//  Purpose  : Input and output stream handshakes of the pooling stage.
//             master = stream source / result sink, slave = pooling block.
//  Revision : 1.0  initial release
// ============================================================================
interface relu_maxpool_if #(
  parameter int DW = 40
);

  logic signed [DW-1:0] INPUT_TDATA;
  logic                 INPUT_TVALID;
  logic                 INPUT_TREADY;
  logic signed [DW-1:0] OUTPUT_TDATA;
  logic                 OUTPUT_TVALID;
  logic                 OUTPUT_TREADY;
  logic                 OUTPUT_TLAST;

  modport master (
    output INPUT_TDATA, INPUT_TVALID, OUTPUT_TREADY,
    input  INPUT_TREADY, OUTPUT_TDATA, OUTPUT_TVALID, OUTPUT_TLAST
  );

  modport slave (
    input  INPUT_TDATA, INPUT_TVALID, OUTPUT_TREADY,
    output INPUT_TREADY, OUTPUT_TDATA, OUTPUT_TVALID, OUTPUT_TLAST
  );

endinterface
`default_nettype wire

// File: rtl/relu_maxpool_linebuf.sv
`default_nettype none
// ============================================================================
//  Module   : pool_linebuf
//  Purpose  : Half-row buffer of horizontal maxima. Written on even rows and
//             read combinationally at the same index on the following row.
//             Contents are never reset: every entry is written before it is
//             read within a frame.
//  Revision : 1.0  initial release
// ============================================================================
module pool_linebuf
  import relu_maxpool_pkg::*;
#(
  parameter int DEPTH = LB_DEPTH,
  parameter int DW    = DW_DEF,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  wire logic                 clk,
  input  wire logic                 we,
  input  wire logic [AW-1:0]        idx,
  input  wire logic signed [DW-1:0] wdata,
  output logic signed [DW-1:0]      rdata
);

  logic signed [DW-1:0] mem [DEPTH];

  // Store the horizontal max of an even row.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  assign rdata = mem[idx];

endmodule
`default_nettype wire

// File: rtl/relu_maxpool.sv
`default_nettype none
// ============================================================================
//  Module   : relu_maxpool
//  Purpose  : Optional ReLU followed by 2x2 stride-2 max pooling over a
//             row-major stream. One pooled value per window, TLAST on the
//             final value of the frame. Single output register with a
//             combinational ready path (1 beat/cycle).
//  Config   : define RELU_POOL_RELU_EN to clamp negative inputs to zero.
//  Revision : 1.0  initial release
// ============================================================================
module relu_maxpool
  import relu_maxpool_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int C_MAX = C_MAX_DEF,
  parameter int R_MAX = R_MAX_DEF
) (
  input  wire logic                        clk,
  input  wire logic                        reset,
  input  wire logic [$clog2(C_MAX+1)-1:0]  IN_COLS,
  input  wire logic [$clog2(R_MAX+1)-1:0]  IN_ROWS,
  relu_maxpool_if.slave                    axis,
  output logic                             frame_done
);

  localparam int CW   = $clog2(C_MAX + 1);
  localparam int RW   = $clog2(R_MAX + 1);
  localparam int LB_D = C_MAX / 2;
  localparam int AW   = (LB_D > 1) ? $clog2(LB_D) : 1;

  state_t               state_q, state_d;
  logic [CW-1:0]        cols_q, cols_d, col_cnt_q, col_cnt_d;
  logic [RW-1:0]        rows_q, rows_d, row_cnt_q, row_cnt_d;
  logic signed [DW-1:0] h_q, h_d;
  logic signed [DW-1:0] out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;

  logic                 in_ready, accept;
  logic [CW-1:0]        cols_eff;
  logic [RW-1:0]        rows_eff;
  logic signed [DW-1:0] v, hmax, lb_rd, result;
  logic                 col_odd, row_odd, end_of_row, end_of_frame, last_pair;
  logic                 lb_we;
  logic [AW-1:0]        lb_idx;

  assign in_ready = reset & (~out_valid_q | axis.OUTPUT_TREADY);
  assign accept   = axis.INPUT_TVALID & in_ready;

  // Datapath: pre-processing, pair maxima and frame position decode.
  // In IDLE the counters are zero and the live IN_COLS/IN_ROWS describe the
  // beat being accepted, so they stand in for the not-yet-latched copies.
  always_comb begin
    cols_eff = (state_q == IDLE) ? IN_COLS : cols_q;
    rows_eff = (state_q == IDLE) ? IN_ROWS : rows_q;
`ifdef RELU_POOL_RELU_EN
    v = axis.INPUT_TDATA[DW-1] ? '0 : axis.INPUT_TDATA;
`else
    v = axis.INPUT_TDATA;
`endif
    hmax         = smax(h_q, v);
    result       = smax(lb_rd, hmax);
    col_odd      = col_cnt_q[0];
    row_odd      = row_cnt_q[0];
    end_of_row   = (col_cnt_q == cols_eff - CW'(1));
    end_of_frame = end_of_row && (row_cnt_q == rows_eff - RW'(1));
    // Last complete window: trailing odd row/column never count.
    last_pair    = (((row_cnt_q >> 1) + RW'(1)) == (rows_eff >> 1)) &&
                   (((col_cnt_q >> 1) + CW'(1)) == (cols_eff >> 1));
    lb_we        = accept & col_odd & ~row_odd;
    lb_idx       = col_cnt_q[AW:1];
  end

  pool_linebuf #(
    .DEPTH (LB_D),
    .DW    (DW),
    .AW    (AW)
  ) u_linebuf (
    .clk   (clk),
    .we    (lb_we),
    .idx   (lb_idx),
    .wdata (hmax),
    .rdata (lb_rd)
  );

  // Next state: frame FSM, counters, horizontal hold and output register.
  always_comb begin
    state_d     = state_q;
    cols_d      = cols_q;
    rows_d      = rows_q;
    col_cnt_d   = col_cnt_q;
    row_cnt_d   = row_cnt_q;
    h_d         = h_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    if (out_valid_q && axis.OUTPUT_TREADY) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      if (state_q == IDLE) begin
        cols_d = IN_COLS;
        rows_d = IN_ROWS;
      end

      if (!col_odd) begin
        h_d = v;
      end

      // A new result may reload the register in the same cycle it drains.
      if (col_odd && row_odd) begin
        out_data_d  = result;
        out_last_d  = last_pair;
        out_valid_d = 1'b1;
      end

      if (end_of_frame) begin
        state_d   = IDLE;
        col_cnt_d = '0;
        row_cnt_d = '0;
      end else begin
        state_d = RUN;
        if (end_of_row) begin
          col_cnt_d = '0;
          row_cnt_d = row_cnt_q + RW'(1);
        end else begin
          col_cnt_d = col_cnt_q + CW'(1);
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cols_q      <= '0;
      rows_q      <= '0;
      col_cnt_q   <= '0;
      row_cnt_q   <= '0;
      h_q         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cols_q      <= cols_d;
      rows_q      <= rows_d;
      col_cnt_q   <= col_cnt_d;
      row_cnt_q   <= row_cnt_d;
      h_q         <= h_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign axis.INPUT_TREADY  = in_ready;
  assign axis.OUTPUT_TDATA  = out_data_q;
  assign axis.OUTPUT_TVALID = out_valid_q;
  assign axis.OUTPUT_TLAST  = out_last_q;
  assign frame_done         = accept & end_of_frame;

endmodule
`default_nettype wire

// File: tb/tb_relu_maxpool.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_relu_maxpool
//  Purpose  : Self-checking bench for relu_maxpool. Expected pooled values
//             are computed from each stimulus frame and queued; a monitor
//             pops and compares them as the output handshake completes.
//  Revision : 1.0  initial release
// ============================================================================
module tb_relu_maxpool;

  localparam int DW    = 40;
  localparam int C_MAX = 8;
  localparam int R_MAX = 8;
  localparam int CW    = $clog2(C_MAX + 1);
  localparam int RW    = $clog2(R_MAX + 1);

  typedef logic signed [DW-1:0] data_t;
  typedef struct packed {
    logic signed [DW-1:0] d;
    logic                 last;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [CW-1:0] in_cols = '0;
  logic [RW-1:0] in_rows = '0;
  logic          frame_done;

  relu_maxpool_if #(.DW(DW)) bus ();

  relu_maxpool #(
    .DW    (DW),
    .C_MAX (C_MAX),
    .R_MAX (R_MAX)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .IN_COLS    (in_cols),
    .IN_ROWS    (in_rows),
    .axis       (bus),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  exp_t  exp_q[$];
  exp_t  e;
  int    n_cmp = 0;
  int    n_err = 0;
  data_t held_d;
  logic  held_l;
  logic  held_v = 1'b0;

  // Output monitor: scoreboard pop on each transfer, stability while stalled.
  always @(negedge clk) begin
    if (!reset) begin
      held_v = 1'b0;
    end else begin
      if (held_v && bus.OUTPUT_TVALID) begin
        n_cmp++;
        if (bus.OUTPUT_TDATA !== held_d || bus.OUTPUT_TLAST !== held_l) begin
          n_err++;
          $display("FAIL stall_stable got=%0d/%0b required=%0d/%0b",
                   bus.OUTPUT_TDATA, bus.OUTPUT_TLAST, held_d, held_l);
        end
      end
      if (bus.OUTPUT_TVALID && bus.OUTPUT_TREADY) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_output got=%0d required=none", bus.OUTPUT_TDATA);
        end else begin
          e = exp_q.pop_front();
          if (bus.OUTPUT_TDATA !== e.d || bus.OUTPUT_TLAST !== e.last) begin
            n_err++;
            $display("FAIL output data/last got=%0d/%0b required=%0d/%0b",
                     bus.OUTPUT_TDATA, bus.OUTPUT_TLAST, e.d, e.last);
          end
        end
        held_v = 1'b0;
      end else if (bus.OUTPUT_TVALID) begin
        held_v = 1'b1;
        held_d = bus.OUTPUT_TDATA;
        held_l = bus.OUTPUT_TLAST;
      end else begin
        held_v = 1'b0;
      end
    end
  end

  function automatic data_t pre(input data_t x);
`ifdef RELU_POOL_RELU_EN
    return (x < 0) ? '0 : x;
`else
    return x;
`endif
  endfunction

  function automatic data_t mx(input data_t a, input data_t b);
    return (a > b) ? a : b;
  endfunction

  // Reference pooling of a whole frame into the scoreboard.
  task automatic push_expected(input data_t vals[$], input int cols, input int rows);
    data_t m;
    exp_t  x;
    for (int r = 0; r + 1 < rows; r += 2) begin
      for (int c = 0; c + 1 < cols; c += 2) begin
        m = mx(mx(pre(vals[r*cols+c]), pre(vals[r*cols+c+1])),
               mx(pre(vals[(r+1)*cols+c]), pre(vals[(r+1)*cols+c+1])));
        x.d    = m;
        x.last = (r == 2*(rows/2) - 2) && (c == 2*(cols/2) - 2);
        exp_q.push_back(x);
      end
    end
  endtask

  // Drive one beat from posedge+1; IN_COLS/IN_ROWS are scrambled after the
  // first beat since the block must ignore them mid-frame.
  task automatic drive_beat(input data_t d, input bit first, input int cols, input int rows,
                            input bit fd_exp, input bit drop_after);
    int t;
    if (first) begin
      in_cols = CW'(cols);
      in_rows = RW'(rows);
    end else begin
      in_cols = CW'($urandom_range(0, 15));
      in_rows = RW'($urandom_range(0, 15));
    end
    bus.INPUT_TDATA  = d;
    bus.INPUT_TVALID = 1'b1;
    t = 0;
    @(negedge clk);
    while (!bus.INPUT_TREADY && t < 200) begin
      t++;
      @(negedge clk);
    end
    n_cmp++;
    if (t >= 200) begin
      n_err++;
      $display("FAIL beat_timeout ready=%0b required=1", bus.INPUT_TREADY);
    end else if (frame_done !== fd_exp) begin
      n_err++;
      $display("FAIL frame_done got=%0b required=%0b", frame_done, fd_exp);
    end
    @(posedge clk);
    #1;
    if (drop_after) bus.INPUT_TVALID = 1'b0;
  endtask

  task automatic send_frame(input data_t vals[$], input int cols, input int rows,
                            input bit hold_valid);
    int n;
    n = cols * rows;
    push_expected(vals, cols, rows);
    for (int i = 0; i < n; i++) begin
      drive_beat(vals[i], i == 0, cols, rows, i == n - 1, (i == n - 1) && !hold_valid);
    end
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || bus.OUTPUT_TVALID) && t < 200) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (exp_q.size() != 0 || t >= 200) begin
      n_err++;
      $display("FAIL %s drain pending=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  function automatic void ramp(output data_t q[$], input int n, input int base);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back(DW'(base + i));
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    bus.INPUT_TVALID = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.OUTPUT_TVALID !== 1'b0 || bus.OUTPUT_TLAST !== 1'b0) begin
      n_err++;
      $display("FAIL reset_valid_last got=%0b/%0b required=0/0", bus.OUTPUT_TVALID, bus.OUTPUT_TLAST);
    end
    n_cmp++;
    if (bus.OUTPUT_TDATA !== '0) begin
      n_err++;
      $display("FAIL reset_data got=%0d required=0", bus.OUTPUT_TDATA);
    end
    n_cmp++;
    if (bus.INPUT_TREADY !== 1'b0 || frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ready_fd got=%0b/%0b required=0/0", bus.INPUT_TREADY, frame_done);
    end
    @(posedge clk);
    #1;
    bus.INPUT_TVALID = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.INPUT_TREADY !== 1'b1) begin
      n_err++;
      $display("FAIL ready_after_reset got=%0b required=1", bus.INPUT_TREADY);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_ramp_4x4();
    data_t q[$];
    ramp(q, 16, 0);
    send_frame(q, 4, 4, 1'b0);
    wait_drain("ramp_4x4");
  endtask

  task automatic test_const_neg();
    data_t q[$];
    for (int i = 0; i < 16; i++) q.push_back(DW'(-5));
    send_frame(q, 4, 4, 1'b0);
    wait_drain("const_neg");
  endtask

  task automatic test_odd_5x5();
    data_t q[$];
    ramp(q, 25, 0);
    send_frame(q, 5, 5, 1'b0);
    wait_drain("odd_5x5");
  endtask

  task automatic test_stall();
    data_t q[$];
    ramp(q, 16, 0);
    fork
      send_frame(q, 4, 4, 1'b0);
      begin
        int t;
        t = 0;
        do begin
          @(posedge clk);
          #1;
          t++;
        end while (!bus.OUTPUT_TVALID && t < 100);
        bus.OUTPUT_TREADY = 1'b0;
        repeat (5) begin
          @(negedge clk);
          n_cmp++;
          if (bus.INPUT_TREADY !== 1'b0 || bus.OUTPUT_TDATA !== DW'(5)) begin
            n_err++;
            $display("FAIL stall ready/data got=%0b/%0d required=0/5",
                     bus.INPUT_TREADY, bus.OUTPUT_TDATA);
          end
        end
        @(posedge clk);
        #1;
        bus.OUTPUT_TREADY = 1'b1;
      end
    join
    wait_drain("stall");
  endtask

  task automatic test_degenerate();
    data_t q[$];
    ramp(q, 3, 20);
    send_frame(q, 3, 1, 1'b0);
    ramp(q, 1, 30);
    send_frame(q, 1, 1, 1'b0);
    ramp(q, 2, 40);
    send_frame(q, 1, 2, 1'b0);
    wait_drain("degenerate");
  endtask

  task automatic test_back_to_back();
    data_t a[$];
    data_t b[$];
    a = '{DW'(1), DW'(9), DW'(3), DW'(4)};
    b = '{DW'(-7), DW'(-2), DW'(-3), DW'(-8)};
    send_frame(a, 2, 2, 1'b1);
    send_frame(b, 2, 2, 1'b0);
    wait_drain("back_to_back");
  endtask

  task automatic test_reset_mid_frame();
    data_t q[$];
    bus.OUTPUT_TREADY = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_beat(DW'(100 + i), i == 0, 4, 4, 1'b0, i == 5);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.OUTPUT_TVALID !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_valid got=%0b required=0", bus.OUTPUT_TVALID);
    end
    @(posedge clk);
    #1;
    bus.OUTPUT_TREADY = 1'b1;
    q = '{DW'(4), DW'(3), DW'(2), DW'(1)};
    send_frame(q, 2, 2, 1'b0);
    wait_drain("reset_mid_frame");
  endtask

  initial begin
    bus.INPUT_TVALID  = 1'b0;
    bus.INPUT_TDATA   = '0;
    bus.OUTPUT_TREADY = 1'b1;
    test_reset();
    test_ramp_4x4();
    test_const_neg();
    test_odd_5x5();
    test_stall();
    test_degenerate();
    test_back_to_back();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
